// File: rtl/powlib_credit_tx_pkg.sv
// Shared constants and helpers for the powlib credit transmitter.
package powlib_credit_tx_pkg;

    localparam int POWLIB_CRED_MAX = 255;

    // Ceiling log2, used to size counters that must hold the value v-1.
    function automatic int powlib_clogb2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/powlib_credit_tx_if.sv
// Write-side handshake plus link/credit signals of the credit transmitter.
// Optional statistics counters appear when POWLIB_CREDIT_TX_STATS_EN is defined.
interface powlib_credit_tx_if
    import powlib_credit_tx_pkg::*;
#(
    parameter int W    = 16,
    parameter int CRED = 8
);
    localparam int WC = powlib_clogb2(CRED + 1);

    logic [W-1:0]  wrdata;
    logic          wrvld;
    logic          wrrdy;
    logic [W-1:0]  txdata;
    logic          txvld;
    logic          crret;
    logic [WC-1:0] crcnt;
    logic          crerr;
`ifdef POWLIB_CREDIT_TX_STATS_EN
    logic [31:0]   txcnt;
    logic [31:0]   stall;
`endif

    modport slave (
        input  wrdata, wrvld, crret,
        output wrrdy, txdata, txvld, crcnt, crerr
`ifdef POWLIB_CREDIT_TX_STATS_EN
        , output txcnt, stall
`endif
    );

    modport master (
        output wrdata, wrvld, crret,
        input  wrrdy, txdata, txvld, crcnt, crerr
`ifdef POWLIB_CREDIT_TX_STATS_EN
        , input txcnt, stall
`endif
    );

endinterface

// File: rtl/powlib_credit_cntr.sv
// Saturating up/down credit counter; o_ovf flags an increment refused at MAX.
module powlib_credit_cntr #(
    parameter int W    = 4,
    parameter int INIT = 8,
    parameter int MAX  = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_zero,
    output logic         o_ovf
);
    logic [W-1:0] r_cnt;
    logic         w_full;
    logic         w_zero;

    assign w_full = (r_cnt == W'(MAX));
    assign w_zero = (r_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            r_cnt <= W'(INIT);
        else if (i_inc && !i_dec && !w_full)
            r_cnt <= r_cnt + 1'b1;
        else if (i_dec && !i_inc && !w_zero)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_cnt  = r_cnt;
    assign o_zero = w_zero;
    assign o_ovf  = i_inc && !i_dec && w_full;

endmodule

// File: rtl/powlib_credit_tx.sv
// Credit-gated transmitter: one registered link stage, one credit spent per word.
// Define POWLIB_CREDIT_TX_STATS_EN to add the txcnt/stall statistics outputs.
module powlib_credit_tx
    import powlib_credit_tx_pkg::*;
#(
    parameter int W    = 16,
    parameter int CRED = 8,
    parameter int EDBG = 0,
    parameter     ID   = "CREDTX"
) (
    input  logic              clk,
    input  logic              rst,
    powlib_credit_tx_if.slave lnk
);
    localparam int WC = powlib_clogb2(CRED + 1);

    if (CRED < 1 || CRED > POWLIB_CRED_MAX) begin : g_bad_cred
        $fatal(1, "%s: CRED must be within 1..%0d", ID, POWLIB_CRED_MAX);
    end

    logic [WC-1:0] w_cnt;
    logic          w_zero;
    logic          w_ovf;
    logic          w_wrinc;
    logic [W-1:0]  r_txdata;
    logic          r_txvld;
    logic          r_crerr;

    // wrrdy comes only from the counter register, so wrvld/crret never reach it.
    assign w_wrinc = lnk.wrvld && !w_zero;

    powlib_credit_cntr #(
        .W    (WC),
        .INIT (CRED),
        .MAX  (CRED)
    ) u_cntr (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_inc  (lnk.crret),
        .i_dec  (w_wrinc),
        .o_cnt  (w_cnt),
        .o_zero (w_zero),
        .o_ovf  (w_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_txdata <= '0;
            r_txvld  <= 1'b0;
            r_crerr  <= 1'b0;
        end else begin
            r_txvld <= w_wrinc;
            if (w_wrinc) r_txdata <= lnk.wrdata;
            if (w_ovf)   r_crerr  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) assert (!(EDBG != 0 && w_ovf))
            else $error("%s: credit overflow at %0t", ID, $time);
    end

    assign lnk.wrrdy  = !w_zero;
    assign lnk.txdata = r_txdata;
    assign lnk.txvld  = r_txvld;
    assign lnk.crcnt  = w_cnt;
    assign lnk.crerr  = r_crerr;

`ifdef POWLIB_CREDIT_TX_STATS_EN
    logic [31:0] r_txcnt;
    logic [31:0] r_stall;

    // txcnt wraps freely; stall saturates so a long stall never reads as short.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_txcnt <= '0;
            r_stall <= '0;
        end else begin
            if (w_wrinc) r_txcnt <= r_txcnt + 32'd1;
            if (lnk.wrvld && w_zero && (r_stall != '1)) r_stall <= r_stall + 32'd1;
        end
    end

    assign lnk.txcnt = r_txcnt;
    assign lnk.stall = r_stall;
`endif

endmodule

// File: tb/tb_powlib_credit_tx.sv
// Directed, table-driven bench for powlib_credit_tx with CRED=4.
module tb_powlib_credit_tx;

    localparam int W    = 16;
    localparam int CRED = 4;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [15:0] d;
        logic        cr;
        logic        e_rdy;
        logic [2:0]  e_cnt;
        logic        e_vld;
        logic [15:0] e_dat;
        logic        e_err;
    } vec_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    vec_t tv[$];

    powlib_credit_tx_if #(.W(W), .CRED(CRED)) lnk ();

    powlib_credit_tx #(.W(W), .CRED(CRED), .EDBG(0), .ID("CREDTX")) u_dut (
        .clk (clk),
        .rst (rst),
        .lnk (lnk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [15:0] d, input logic c,
                       input logic er, input logic [2:0] ec, input logic ev,
                       input logic [15:0] ed, input logic ee);
        vec_t x;
        x.rst = r; x.vld = v; x.d = d; x.cr = c;
        x.e_rdy = er; x.e_cnt = ec; x.e_vld = ev; x.e_dat = ed; x.e_err = ee;
        tv.push_back(x);
    endtask

    task automatic drive(input logic r, input logic v, input logic [15:0] d, input logic c);
        rst        = r;
        lnk.wrvld  = v;
        lnk.wrdata = d;
        lnk.crret  = c;
    endtask

    task automatic check_state(input string tag, input logic er, input logic [2:0] ec,
                               input logic ev, input logic [15:0] ed, input logic ee);
        check({tag, ".wrrdy"},  32'(lnk.wrrdy),  32'(er));
        check({tag, ".crcnt"},  32'(lnk.crcnt),  32'(ec));
        check({tag, ".txvld"},  32'(lnk.txvld),  32'(ev));
        check({tag, ".txdata"}, 32'(lnk.txdata), 32'(ed));
        check({tag, ".crerr"},  32'(lnk.crerr),  32'(ee));
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        // Expected values are the outputs after the edge that consumes the row's inputs.
        //  rst vld data    cr   rdy cnt vld txdata  err
        add(1, 0, 16'h0000, 0,   1, 4, 0, 16'h0000, 0);
        add(1, 1, 16'h0010, 0,   1, 3, 1, 16'h0010, 0);
        add(1, 1, 16'h0011, 0,   1, 2, 1, 16'h0011, 0);
        add(1, 1, 16'h0012, 0,   1, 1, 1, 16'h0012, 0);
        add(1, 1, 16'h0013, 0,   0, 0, 1, 16'h0013, 0);
        add(1, 1, 16'h0014, 0,   0, 0, 0, 16'h0013, 0);
        add(1, 1, 16'h0014, 0,   0, 0, 0, 16'h0013, 0);
        // credit return while starved: not usable in the same cycle
        add(1, 1, 16'h0014, 1,   1, 1, 0, 16'h0013, 0);
        add(1, 1, 16'h0014, 0,   0, 0, 1, 16'h0014, 0);
        add(1, 0, 16'h0000, 1,   1, 1, 0, 16'h0014, 0);
        add(1, 0, 16'h0000, 1,   1, 2, 0, 16'h0014, 0);
        // simultaneous send and return at crcnt=2
        for (int i = 0; i < 5; i++)
            add(1, 1, 16'h0020 + 16'(i), 1, 1, 2, 1, 16'h0020 + 16'(i), 0);
        add(1, 0, 16'h0000, 1,   1, 3, 0, 16'h0024, 0);
        add(1, 0, 16'h0000, 1,   1, 4, 0, 16'h0024, 0);
        // return at CRED alongside a send is legal
        add(1, 1, 16'h0030, 1,   1, 4, 1, 16'h0030, 0);
        // return alone at CRED overflows and latches crerr
        add(1, 0, 16'h0000, 1,   1, 4, 0, 16'h0030, 1);
        for (int i = 0; i < 10; i++)
            add(1, 0, 16'h0000, 0, 1, 4, 0, 16'h0030, 1);
        add(1, 1, 16'h0040, 0,   1, 3, 1, 16'h0040, 1);
        add(1, 1, 16'h0041, 0,   1, 2, 1, 16'h0041, 1);

        drive(0, 0, 16'h0000, 0);
        #12;
        check_state("reset", 1, 4, 0, 16'h0000, 0);

        @(negedge clk);
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].vld, tv[i].d, tv[i].cr);
            @(negedge clk);
            check_state($sformatf("row%0d", i), tv[i].e_rdy, tv[i].e_cnt,
                        tv[i].e_vld, tv[i].e_dat, tv[i].e_err);
        end

        // Mid-burst async reset: txvld is high right now and must drop at once.
        drive(0, 1, 16'h0042, 0);
        #1;
        check_state("async_rst", 1, 4, 0, 16'h0000, 0);
        @(negedge clk);
        check_state("rst_hold", 1, 4, 0, 16'h0000, 0);

        drive(1, 1, 16'h0050, 0);
        @(negedge clk);
        check_state("post_rst", 1, 3, 1, 16'h0050, 0);

`ifdef POWLIB_CREDIT_TX_STATS_EN
        drive(0, 0, 16'h0000, 0);
        #1;
        check("stats_rst.txcnt", lnk.txcnt, 32'd0);
        check("stats_rst.stall", lnk.stall, 32'd0);
        @(negedge clk);
        drive(1, 0, 16'h0000, 0);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 16'h0060 + 16'(i), 0);
            @(negedge clk);
        end
        drive(1, 0, 16'h0000, 0);
        @(negedge clk);
        check("stats.txcnt", lnk.txcnt, 32'd4);
        check("stats.stall", lnk.stall, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/powlib_credit_tx.md
Name: powlib_credit_tx

Overview:
- Transmitter end of a credit-flow link into a remote powlib FIFO, typically across a clock-domain or long pipeline boundary.
- Accepts words on a valid/ready write interface and forwards each accepted word onto a registered link (txdata/txvld, no back-pressure).
- Spends one credit per word and regains one credit per crret pulse from the receiver, which pulses crret when it pops a word.
- Never sends more words than the remote FIFO can hold, so the receiver needs no nearly-full pipeline margin.

Parameters:
- W, 16, data width.
- CRED, 8, initial and maximum credits; equals remote FIFO depth; range 1..255.
- EDBG, 0, enable $display of credit errors.
- ID, "CREDTX", string identifier used in messages.
- Local: WC = powlib_clogb2(CRED+1), credit counter width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low. All flops clear immediately on rst=0 and release on a clk edge after rst=1.
- wrdata  input  W  write interface data.
- wrvld  input  1  write data valid.
- wrrdy  output  1  ready; high when credits are available.
- txdata  output  W  link data, registered.
- txvld  output  1  link valid, registered one-cycle pulse per word.
- crret  input  1  credit return; one credit per cycle high.
- crcnt  output  WC  current credit count.
- crerr  output  1  sticky credit-overflow error.

Behaviour:
- Reset values: crcnt=CRED, wrrdy=1, txvld=0, txdata=0, crerr=0.
- wrrdy = (crcnt!=0), driven from the register only; no combinational path from wrvld or crret.
- wrinc = wrvld && wrrdy.
- Latency: on a wrinc cycle, txdata<=wrdata and txvld<=1 at the next edge. Otherwise txvld<=0 and txdata holds its value. Exactly one cycle of latency, full throughput.
- Credit counter update per edge:
  - wrinc only: crcnt-1.
  - crret only: crcnt+1.
  - both: unchanged.
  - neither: unchanged.
- A returned credit is usable the cycle after crret, never in the same cycle. Exception: with crcnt=0 and both crret=1 and wrvld=1, wrrdy=0, so no send occurs and crcnt becomes 1.
- Empty boundary: at crcnt=0, wrrdy=0 and wrvld is ignored; crcnt never goes below 0.
- Overflow boundary: crret alone with crcnt==CRED saturates crcnt at CRED and sets crerr=1. crerr stays set until reset. With EDBG!=0, also $display ID and time.
- crret while crcnt==CRED together with a wrinc is legal: net unchanged, no error.
- Reset mid-operation: any in-flight txvld is dropped and credits restore to CRED. The receiver must be reset in the same reset event.
- No state machine beyond the counter and output register; the block is a pure credit gate plus one pipeline stage.

Optional Feature:
- Macro: POWLIB_CREDIT_TX_STATS_EN.
- When defined: adds output txcnt [31:0], a free-running count of words sent, incremented on every wrinc. It wraps from 0xFFFFFFFF to 0 and resets to 0.
- Also adds output stall [31:0], a count of cycles with wrvld=1 and wrrdy=0. It saturates at 0xFFFFFFFF and resets to 0.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared header powlib_std.vh supplies powlib_clogb2. Add constant POWLIB_CRED_MAX=255 there for the parameter check.
- Initial block: $finish if CRED<1 or CRED>POWLIB_CRED_MAX.
- One sub-module: powlib_credit_cntr. It is a saturating up/down counter with parameters W, INIT and MAX, inputs inc/dec, and outputs cnt/zero/ovf. The async active-low reset is passed through to it.
- Output register uses powlib_flipflop with EVLD(1).

Test Plan:
- Reset, CRED=4: after rst release, crcnt=4, wrrdy=1, txvld=0, crerr=0. Assert rst=0 mid-burst: txvld drops within the same cycle and crcnt=4.
- Burst until empty: wrvld=1 for 6 cycles with data 0x10..0x15, no crret. Expect txvld high for 4 cycles carrying 0x10..0x13, each one cycle after acceptance. Then crcnt=0 and wrrdy=0 while 0x14 is held.
- Credit return: from crcnt=0 with wrvld=1 and data 0x14, pulse crret once. Next cycle crcnt=1 and wrrdy=1; 0x14 is accepted and sent; crcnt returns to 0.
- Simultaneous: crcnt=2, wrvld=1 and crret=1 for 5 cycles. Expect crcnt to stay at 2, 5 words sent back-to-back, crerr=0.
- Overflow: at crcnt=4 (=CRED), pulse crret with wrvld=0. Expect crcnt=4 and crerr=1, still 1 after 10 idle cycles, cleared only by rst=0.
- With POWLIB_CREDIT_TX_STATS_EN, CRED=2, wrvld=1 for 5 cycles, no crret: expect txcnt=2 and stall=3.
